// File: rtl/axi_line_master.sv
// ============================================================================
//  Module   : axi_line_master
//  Purpose  : Turns one 128-bit cache line request into a single-beat AXI
//             read or write and returns the line / status to the cache.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module axi_line_master #(
    parameter int          ADDR_W = 64,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    // cache request / completion
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [127:0]      req_wdata_i,
    input  logic [15:0]       req_wstrb_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_write_o,
    output logic [127:0]      resp_rdata_o,
    output logic              resp_err_o,
    // AXI read address / data
    output logic              axi_readAddr_valid_o,
    input  logic              axi_readAddr_ready_i,
    output logic [ADDR_W-1:0] axi_readAddr_bits_addr_o,
    output logic [2:0]        axi_readAddr_bits_prot_o,
    input  logic              axi_readData_valid_i,
    output logic              axi_readData_ready_o,
    input  logic [127:0]      axi_readData_bits_data_i,
    input  logic [1:0]        axi_readData_bits_resp_i,
    // AXI write address / data / response
    output logic              axi_writeAddr_valid_o,
    input  logic              axi_writeAddr_ready_i,
    output logic [ADDR_W-1:0] axi_writeAddr_bits_addr_o,
    output logic [2:0]        axi_writeAddr_bits_prot_o,
    output logic              axi_writeData_valid_o,
    input  logic              axi_writeData_ready_i,
    output logic [127:0]      axi_writeData_bits_data_o,
    output logic [15:0]       axi_writeData_bits_strb_o,
    input  logic              axi_writeResp_valid_i,
    output logic              axi_writeResp_ready_o,
    input  logic [1:0]        axi_writeResp_bits_i
);

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_RD_ADDR = 3'd1;
    localparam logic [2:0] C_RD_DATA = 3'd2;
    localparam logic [2:0] C_WR_REQ  = 3'd3;
    localparam logic [2:0] C_WR_RESP = 3'd4;
    localparam logic [2:0] C_DONE    = 3'd5;

    logic [2:0]        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [127:0]      wdata_q,   wdata_d;
    logic [15:0]       wstrb_q,   wstrb_d;
    logic              write_q,   write_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;
    logic [127:0]      rdata_q,   rdata_d;
    logic              err_q,     err_d;

    logic w_aw_hs;
    logic w_w_hs;

    // All handshake outputs decode from registered state only.
    assign req_ready_o           = (state_q == C_IDLE);
    assign axi_readAddr_valid_o  = (state_q == C_RD_ADDR);
    assign axi_readData_ready_o  = (state_q == C_RD_DATA);
    assign axi_writeAddr_valid_o = (state_q == C_WR_REQ) && !aw_done_q;
    assign axi_writeData_valid_o = (state_q == C_WR_REQ) && !w_done_q;
    assign axi_writeResp_ready_o = (state_q == C_WR_RESP);
    assign resp_valid_o          = (state_q == C_DONE);

    assign axi_readAddr_bits_addr_o  = addr_q;
    assign axi_writeAddr_bits_addr_o = addr_q;
    assign axi_readAddr_bits_prot_o  = PROT;
    assign axi_writeAddr_bits_prot_o = PROT;
    assign axi_writeData_bits_data_o = wdata_q;
    assign axi_writeData_bits_strb_o = wstrb_q;
    assign resp_write_o              = write_q;
    assign resp_rdata_o              = rdata_q;
    assign resp_err_o                = err_q;

    assign w_aw_hs = axi_writeAddr_valid_o && axi_writeAddr_ready_i;
    assign w_w_hs  = axi_writeData_valid_o && axi_writeData_ready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            C_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = {req_addr_i[ADDR_W-1:4], 4'b0000};
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    write_d = req_write_i;
                    state_d = req_write_i ? C_WR_REQ : C_RD_ADDR;
                end
            end
            C_RD_ADDR: begin
                if (axi_readAddr_ready_i) state_d = C_RD_DATA;
            end
            C_RD_DATA: begin
                if (axi_readData_valid_i) begin
                    rdata_d = axi_readData_bits_data_i;
                    err_d   = (axi_readData_bits_resp_i != 2'b00);
                    state_d = C_DONE;
                end
            end
            C_WR_REQ: begin
                if (w_aw_hs) aw_done_d = 1'b1;
                if (w_w_hs)  w_done_d  = 1'b1;
                // AW and W complete independently, possibly in the same cycle.
                if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = C_WR_RESP;
                end
            end
            C_WR_RESP: begin
                if (axi_writeResp_valid_i) begin
                    rdata_d = '0;
                    err_d   = (axi_writeResp_bits_i != 2'b00);
                    state_d = C_DONE;
                end
            end
            C_DONE: begin
                if (resp_ready_i) state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= C_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule

`default_nettype wire
